// File: rtl/reorder_buffer_if.sv
// Bundles the issue, write-back, query and retire signals of the reorder buffer.
// The core-side agent drives the master modport and the ROB uses the slave modport.
interface reorder_buffer_if #(
  parameter int unsigned ROB_ADDR = 3
);
  logic                issue_valid;
  logic [1:0]          issue_type;
  logic [4:0]          issue_rd;
  logic [31:0]         issue_pc;
  logic                issue_pred_taken;
  logic                issue_ready;
  logic [31:0]         issue_value;
  logic [ROB_ADDR-1:0] issue_tag;
  logic                rob_full;
  logic                rob_empty;

  logic                wb_valid;
  logic [ROB_ADDR-1:0] wb_tag;
  logic [31:0]         wb_value;
  logic                wb_taken;
  logic [31:0]         wb_target;

  logic [ROB_ADDR-1:0] q1_tag;
  logic [ROB_ADDR-1:0] q2_tag;
  logic                q1_ready;
  logic                q2_ready;
  logic [31:0]         q1_value;
  logic [31:0]         q2_value;

  logic                commit_valid;
  logic [4:0]          commit_regid;
  logic [31:0]         commit_value;
  logic [ROB_ADDR-1:0] commit_robindex;
  logic                store_commit;
  logic [ROB_ADDR-1:0] store_tag;
  logic                rf_clear;
  logic [31:0]         redirect_pc;
  logic                halt_out;

  modport master (
    output issue_valid, issue_type, issue_rd, issue_pc, issue_pred_taken, issue_ready, issue_value,
    output wb_valid, wb_tag, wb_value, wb_taken, wb_target, q1_tag, q2_tag,
    input  issue_tag, rob_full, rob_empty, q1_ready, q2_ready, q1_value, q2_value,
    input  commit_valid, commit_regid, commit_value, commit_robindex,
    input  store_commit, store_tag, rf_clear, redirect_pc, halt_out
  );

  modport slave (
    input  issue_valid, issue_type, issue_rd, issue_pc, issue_pred_taken, issue_ready, issue_value,
    input  wb_valid, wb_tag, wb_value, wb_taken, wb_target, q1_tag, q2_tag,
    output issue_tag, rob_full, rob_empty, q1_ready, q2_ready, q1_value, q2_value,
    output commit_valid, commit_regid, commit_value, commit_robindex,
    output store_commit, store_tag, rf_clear, redirect_pc, halt_out
  );
endinterface

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates at tail, captures CDB write-backs, forwards
// operands and retires the head in program order with store release and flush.
module reorder_buffer #(
  parameter int unsigned ROB_ADDR = 3
) (
  input  logic           clk_in,
  input  logic           rst_in,
  input  logic           rdy_in,
  reorder_buffer_if.slave bus
);
  localparam int unsigned DEPTH = 1 << ROB_ADDR;
  localparam int unsigned CW    = ROB_ADDR + 1;

  typedef enum logic [1:0] {T_REG = 2'b00, T_STORE = 2'b01, T_BRANCH = 2'b10, T_EXIT = 2'b11} rob_type_e;

  logic [ROB_ADDR-1:0] head, tail;
  logic [CW-1:0]       count;
  logic [DEPTH-1:0]    busy, done;
  rob_type_e           typ   [DEPTH];
  logic [4:0]          rd    [DEPTH];
  logic [31:0]         pc    [DEPTH];
  logic [31:0]         val   [DEPTH];
  logic [31:0]         tgt   [DEPTH];
  logic [DEPTH-1:0]    pred, tkn;

  logic head_fire, mispredict, issue_fire, wb_fire;

  assign bus.issue_tag = tail;
  assign bus.rob_full  = (count == CW'(DEPTH));
  assign bus.rob_empty = (count == '0);

  // A mispredicting commit squashes everything else happening on the same edge.
  always_comb begin
    head_fire  = !bus.halt_out && busy[head] && done[head];
    mispredict = head_fire && (typ[head] == T_BRANCH) && (tkn[head] != pred[head]);
    issue_fire = bus.issue_valid && !bus.rob_full && !mispredict;
    wb_fire    = bus.wb_valid && busy[bus.wb_tag] && !done[bus.wb_tag] && !mispredict;
  end

  // Operand queries, with the CDB result bypassing the stored value.
  always_comb begin
    bus.q1_ready = done[bus.q1_tag];
    bus.q1_value = val[bus.q1_tag];
    bus.q2_ready = done[bus.q2_tag];
    bus.q2_value = val[bus.q2_tag];
    if (bus.wb_valid && (bus.wb_tag == bus.q1_tag)) begin
      bus.q1_ready = 1'b1;
      bus.q1_value = bus.wb_value;
    end
    if (bus.wb_valid && (bus.wb_tag == bus.q2_tag)) begin
      bus.q2_ready = 1'b1;
      bus.q2_value = bus.wb_value;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      head                <= '0;
      tail                <= '0;
      count               <= '0;
      busy                <= '0;
      done                <= '0;
      pred                <= '0;
      tkn                 <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        typ[i] <= T_REG;
        rd[i]  <= '0;
        pc[i]  <= '0;
        val[i] <= '0;
        tgt[i] <= '0;
      end
      bus.commit_valid    <= 1'b0;
      bus.commit_regid    <= '0;
      bus.commit_value    <= '0;
      bus.commit_robindex <= '0;
      bus.store_commit    <= 1'b0;
      bus.store_tag       <= '0;
      bus.rf_clear        <= 1'b0;
      bus.redirect_pc     <= '0;
      bus.halt_out        <= 1'b0;
    end else if (rdy_in) begin
      bus.commit_valid <= 1'b0;
      bus.store_commit <= 1'b0;
      bus.rf_clear     <= 1'b0;

      if (wb_fire) begin
        val[bus.wb_tag]  <= bus.wb_value;
        tkn[bus.wb_tag]  <= bus.wb_taken;
        tgt[bus.wb_tag]  <= bus.wb_target;
        done[bus.wb_tag] <= 1'b1;
      end

      if (issue_fire) begin
        busy[tail] <= 1'b1;
        done[tail] <= bus.issue_ready;
        typ[tail]  <= rob_type_e'(bus.issue_type);
        rd[tail]   <= (rob_type_e'(bus.issue_type) == T_REG) ? bus.issue_rd : 5'd0;
        pc[tail]   <= bus.issue_pc;
        pred[tail] <= bus.issue_pred_taken;
        val[tail]  <= bus.issue_value;
        tkn[tail]  <= 1'b0;
        tgt[tail]  <= '0;
        tail       <= tail + ROB_ADDR'(1);
      end

      if (head_fire) begin
        busy[head] <= 1'b0;
        done[head] <= 1'b0;
        head       <= head + ROB_ADDR'(1);
        if (typ[head] == T_EXIT) begin
          bus.halt_out <= 1'b1;
        end else begin
          bus.commit_valid    <= 1'b1;
          bus.commit_regid    <= rd[head];
          bus.commit_value    <= val[head];
          bus.commit_robindex <= head;
        end
        if (typ[head] == T_STORE) begin
          bus.store_commit <= 1'b1;
          bus.store_tag    <= head;
        end
        if (mispredict) begin
          bus.rf_clear    <= 1'b1;
          bus.redirect_pc <= tkn[head] ? tgt[head] : pc[head] + 32'd4;
        end
      end

      count <= count + CW'(issue_fire) - CW'(head_fire);

      if (mispredict) begin
        busy  <= '0;
        done  <= '0;
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end
    end
  end
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: stimulus pushes expected retire events into a
// scoreboard queue that a negedge monitor pops whenever the DUT pulses a commit.
module tb_reorder_buffer;
  localparam logic [1:0] T_REG = 2'b00, T_STORE = 2'b01, T_BRANCH = 2'b10, T_EXIT = 2'b11;

  typedef struct {
    logic        st;
    logic        clr;
    logic [4:0]  regid;
    logic [31:0] value;
    logic [2:0]  idx;
    logic [31:0] redirect;
  } exp_t;

  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  logic rdy_in = 1'b1;
  int   n_cmp  = 0;
  int   n_bad  = 0;
  exp_t sb[$];

  reorder_buffer_if #(.ROB_ADDR(3)) bus ();
  reorder_buffer #(.ROB_ADDR(3)) dut (.clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .bus(bus));

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%h, required 0x%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
    bus.issue_valid = 1'b0;
    bus.wb_valid    = 1'b0;
  endtask

  task automatic issue(input logic [1:0] t, input logic [4:0] rd, input logic [31:0] pc,
                       input logic pred, input logic rdy, input logic [31:0] val);
    bus.issue_valid      = 1'b1;
    bus.issue_type       = t;
    bus.issue_rd         = rd;
    bus.issue_pc         = pc;
    bus.issue_pred_taken = pred;
    bus.issue_ready      = rdy;
    bus.issue_value      = val;
    tick();
  endtask

  task automatic wb(input logic [2:0] tag, input logic [31:0] val, input logic taken, input logic [31:0] target);
    bus.wb_valid  = 1'b1;
    bus.wb_tag    = tag;
    bus.wb_value  = val;
    bus.wb_taken  = taken;
    bus.wb_target = target;
    tick();
  endtask

  task automatic expect_commit(input logic st, input logic clr, input logic [4:0] regid,
                               input logic [31:0] value, input logic [2:0] idx, input logic [31:0] redirect);
    exp_t e;
    e.st = st; e.clr = clr; e.regid = regid; e.value = value; e.idx = idx; e.redirect = redirect;
    sb.push_back(e);
  endtask

  task automatic rst_pulse();
    @(posedge clk_in);
    #3 rst_in = 1'b0;
    #3 rst_in = 1'b1;
    tick();
  endtask

  task automatic wait_empty(input string name);
    int k = 0;
    while (!bus.rob_empty && k < 50) begin
      tick();
      k++;
    end
    check(name, 32'(bus.rob_empty), 32'd1);
  endtask

  // Retire monitor: every commit/store/flush pulse must match the oldest expectation.
  always @(negedge clk_in) begin
    if (rst_in && (bus.commit_valid || bus.store_commit || bus.rf_clear)) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_commit: got regid %0d value 0x%h idx %0d, required no commit",
                 bus.commit_regid, bus.commit_value, bus.commit_robindex);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("commit_valid", 32'(bus.commit_valid), 32'd1);
        check("store_commit", 32'(bus.store_commit), 32'(e.st));
        check("rf_clear", 32'(bus.rf_clear), 32'(e.clr));
        check("commit_regid", 32'(bus.commit_regid), 32'(e.regid));
        check("commit_value", bus.commit_value, e.value);
        check("commit_robindex", 32'(bus.commit_robindex), 32'(e.idx));
        if (e.st) check("store_tag", 32'(bus.store_tag), 32'(e.idx));
        if (e.clr) check("redirect_pc", bus.redirect_pc, e.redirect);
      end
    end
  end

  initial begin
    bus.issue_valid = 1'b0; bus.issue_type = T_REG; bus.issue_rd = '0; bus.issue_pc = '0;
    bus.issue_pred_taken = 1'b0; bus.issue_ready = 1'b0; bus.issue_value = '0;
    bus.wb_valid = 1'b0; bus.wb_tag = '0; bus.wb_value = '0; bus.wb_taken = 1'b0; bus.wb_target = '0;
    bus.q1_tag = '0; bus.q2_tag = '0;

    // Reset state.
    #2;
    check("rst_commit_valid", 32'(bus.commit_valid), 32'd0);
    check("rst_halt", 32'(bus.halt_out), 32'd0);
    check("rst_redirect", bus.redirect_pc, 32'd0);
    check("rst_empty", 32'(bus.rob_empty), 32'd1);
    check("rst_full", 32'(bus.rob_full), 32'd0);
    check("rst_issue_tag", 32'(bus.issue_tag), 32'd0);
    #10 rst_in = 1'b1;
    tick();

    // In-order retire with out-of-order write-backs.
    check("io_tag0", 32'(bus.issue_tag), 32'd0);
    issue(T_REG, 5'd1, 32'h0, 1'b0, 1'b0, 32'h0);
    issue(T_REG, 5'd2, 32'h4, 1'b0, 1'b0, 32'h0);
    issue(T_REG, 5'd3, 32'h8, 1'b0, 1'b0, 32'h0);
    check("io_tag3", 32'(bus.issue_tag), 32'd3);
    wb(3'd2, 32'h30, 1'b0, 32'h0);
    expect_commit(1'b0, 1'b0, 5'd1, 32'h10, 3'd0, 32'h0);
    wb(3'd0, 32'h10, 1'b0, 32'h0);
    tick();
    tick();
    expect_commit(1'b0, 1'b0, 5'd2, 32'h20, 3'd1, 32'h0);
    expect_commit(1'b0, 1'b0, 5'd3, 32'h30, 3'd2, 32'h0);
    wb(3'd1, 32'h20, 1'b0, 32'h0);
    tick();
    check("io_second", 32'(bus.commit_regid), 32'd2);
    tick();
    check("io_third", 32'(bus.commit_regid), 32'd3);
    wait_empty("io_drain");

    // Full, ignored ninth issue, and tail wrap.
    rst_pulse();
    for (int i = 0; i < 8; i++) issue(T_REG, 5'(i + 1), 32'(i * 4), 1'b0, 1'b0, 32'h0);
    check("full_set", 32'(bus.rob_full), 32'd1);
    check("full_tag_wrap", 32'(bus.issue_tag), 32'd0);
    issue(T_REG, 5'd31, 32'h0, 1'b0, 1'b1, 32'hBAD);
    check("full_ninth_ignored", 32'(bus.rob_full), 32'd1);
    expect_commit(1'b0, 1'b0, 5'd1, 32'hA0, 3'd0, 32'h0);
    wb(3'd0, 32'hA0, 1'b0, 32'h0);
    tick();
    check("full_after_commit", 32'(bus.rob_full), 32'd0);
    check("wrap_tag0", 32'(bus.issue_tag), 32'd0);
    issue(T_REG, 5'd9, 32'h40, 1'b0, 1'b0, 32'h0);
    check("wrap_full_again", 32'(bus.rob_full), 32'd1);
    for (int i = 1; i < 8; i++) begin
      expect_commit(1'b0, 1'b0, 5'(i + 1), 32'h100 + 32'(i), 3'(i), 32'h0);
      wb(3'(i), 32'h100 + 32'(i), 1'b0, 32'h0);
    end
    expect_commit(1'b0, 1'b0, 5'd9, 32'h900, 3'd0, 32'h0);
    wb(3'd0, 32'h900, 1'b0, 32'h0);
    wait_empty("wrap_drain");

    // Mispredict flush with younger ready entries behind the branch.
    rst_pulse();
    issue(T_BRANCH, 5'd7, 32'h100, 1'b0, 1'b0, 32'h0);
    issue(T_REG, 5'd5, 32'h104, 1'b0, 1'b1, 32'h55);
    issue(T_STORE, 5'd6, 32'h108, 1'b0, 1'b1, 32'h66);
    expect_commit(1'b0, 1'b1, 5'd0, 32'h104, 3'd0, 32'h200);
    wb(3'd0, 32'h104, 1'b1, 32'h200);
    tick();
    check("flush_pulse", 32'(bus.rf_clear), 32'd1);
    check("flush_redirect", bus.redirect_pc, 32'h200);
    check("flush_empty", 32'(bus.rob_empty), 32'd1);
    check("flush_tag", 32'(bus.issue_tag), 32'd0);
    tick();
    check("flush_one_cycle", 32'(bus.rf_clear), 32'd0);
    for (int i = 0; i < 5; i++) tick();
    issue(T_BRANCH, 5'd0, 32'h300, 1'b1, 1'b0, 32'h0);
    expect_commit(1'b0, 1'b1, 5'd0, 32'h0, 3'd0, 32'h304);
    wb(3'd0, 32'h0, 1'b0, 32'h0);
    tick();
    check("nt_redirect", bus.redirect_pc, 32'h304);
    tick();
    issue(T_BRANCH, 5'd0, 32'h400, 1'b1, 1'b0, 32'h0);
    expect_commit(1'b0, 1'b0, 5'd0, 32'h404, 3'd0, 32'h0);
    wb(3'd0, 32'h404, 1'b1, 32'h500);
    tick();
    check("ok_pred_no_clear", 32'(bus.rf_clear), 32'd0);
    check("ok_pred_redirect_held", bus.redirect_pc, 32'h304);
    wait_empty("branch_drain");

    // Query bypass from the CDB, then from storage.
    rst_pulse();
    for (int i = 0; i < 4; i++) issue(T_REG, 5'(i + 10), 32'h0, 1'b0, 1'b0, 32'h0);
    bus.q1_tag = 3'd3;
    bus.q2_tag = 3'd1;
    bus.wb_valid = 1'b1; bus.wb_tag = 3'd3; bus.wb_value = 32'hDEAD; bus.wb_taken = 1'b0;
    #1;
    check("q1_bypass_ready", 32'(bus.q1_ready), 32'd1);
    check("q1_bypass_value", bus.q1_value, 32'hDEAD);
    check("q2_not_ready", 32'(bus.q2_ready), 32'd0);
    tick();
    check("q1_stored_ready", 32'(bus.q1_ready), 32'd1);
    check("q1_stored_value", bus.q1_value, 32'hDEAD);
    rst_pulse();

    // Store release, then exit halts retirement for good.
    expect_commit(1'b1, 1'b0, 5'd0, 32'h77, 3'd0, 32'h0);
    issue(T_STORE, 5'd8, 32'h500, 1'b0, 1'b1, 32'h77);
    issue(T_EXIT, 5'd0, 32'h504, 1'b0, 1'b1, 32'h0);
    tick();
    check("halt_set", 32'(bus.halt_out), 32'd1);
    issue(T_REG, 5'd4, 32'h508, 1'b0, 1'b1, 32'h44);
    for (int i = 0; i < 5; i++) tick();
    check("halt_sticky", 32'(bus.halt_out), 32'd1);
    check("halt_blocks_commit", 32'(bus.rob_empty), 32'd0);

    // Asynchronous reset mid-cycle clears outputs at once.
    @(posedge clk_in);
    #3 rst_in = 1'b0;
    #1;
    check("arst_halt", 32'(bus.halt_out), 32'd0);
    check("arst_commit_value", bus.commit_value, 32'd0);
    check("arst_empty", 32'(bus.rob_empty), 32'd1);
    check("arst_tag", 32'(bus.issue_tag), 32'd0);
    #3 rst_in = 1'b1;
    tick();
    tick();
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
